shift_register_universal: RTL
=============================

// Module: shift_register_universal
// PURPOSE
// Parametrised universal shift register: WIDTH bits, hold / shift-right / shift-left / parallel-load modes,
// optional rotate, and a burst controller that performs a programmed number of shifts autonomously.
// Successor to the fixed 4-bit right-shift JK chain. Used by datapath and serial-I/O experiments
// that need bidirectional shifting, parallel load and counted shift sequences.
// PARAMETERS
// WIDTH        8   register width in bits (>=2)
// COUNT_WIDTH  4   width of burst shift-count input; max burst = 2**COUNT_WIDTH-1 shifts
// PORTS
// clockpulse        in   1            single clock, all state updates on rising edge
// clear             in   1            synchronous active-high reset
// mode              in   2            00 hold, 01 shift right, 10 shift left, 11 parallel load
// rotate            in   1            1: shifted-out bit re-enters at the opposite end; serial inputs ignored
// serialInputRight  in   1            bit entering out[0] on right shift
// serialInputLeft   in   1            bit entering out[WIDTH-1] on left shift
// preset            in   WIDTH        parallel-load data
// start             in   1            one-cycle request to begin a burst
// count             in   COUNT_WIDTH  number of shifts for burst, sampled with start
// out               out  WIDTH        register contents
// notout            out  WIDTH        ~out, combinational
// serialOutRight    out  1            out[WIDTH-1] (bit leaving on right shift)
// serialOutLeft     out  1            out[0] (bit leaving on left shift)
// busy              out  1            burst in progress
// done              out  1            one-cycle pulse at end of burst
// BEHAVIOUR
// - Reset (clear=1 at edge): out=0, busy=0, done=0, internal counter=0, latched direction=right. Overrides all.
// - Right shift: out[0]<=SI, out[i]<=out[i-1]; SI = rotate ? out[WIDTH-1] : serialInputRight.
// - Left shift: out[WIDTH-1]<=SI, out[i]<=out[i+1]; SI = rotate ? out[0] : serialInputLeft.
// - Idle (busy=0): each edge applies mode directly; 11 loads preset; 00 holds. Zero latency: effect visible after that edge.
// - Burst accept: busy=0, start=1, mode in {01,10}: latch direction from mode, counter<=count, busy<=1.
//   That same edge also performs the normal mode operation (first shift happens on the accept edge)
//   -> counter effectively loads count-1 remaining; if count==1 busy stays 0 and done pulses next cycle.
// - count==0 with start: no shift on accept edge (mode treated as hold), busy stays 0, done=1 next cycle.
// - start with mode 00 or 11: ignored as burst; mode still applied as idle operation; no done.
// - Busy: one shift per edge in latched direction; mode, preset, start, count ignored; rotate and serial inputs still honoured live.
//   On the edge performing the final shift: busy<=0, done<=1 for exactly one cycle.
// - Total shifts for accepted burst = count exactly; busy high for count-1 cycles; done asserted the cycle after the last shift.
// - start while busy or while done=1: start ignored while busy; accepted normally while done=1 (back-to-back bursts allowed).
// - clear mid-burst: aborts, out=0, busy=0, no done pulse.
// - notout, serialOutRight, serialOutLeft are pure functions of out; never X after first clear.
// FSM: IDLE -(start & shift mode & count>=2)-> BUSY; BUSY -(remaining==1, shift)-> IDLE with done; any -clear-> IDLE.
// TESTING (WIDTH=8, COUNT_WIDTH=4)
// 1 clear=1 one edge with preset=FF, mode=11 -> out=00, notout=FF, busy=0, done=0.
// 2 mode=11 preset=A5; then mode=01 serialInputRight=1 one edge -> out=4B; mode=10 serialInputLeft=0 -> out=25.
// 3 out=81, rotate=1, mode=01 two edges -> 03 then 06; mode=10 one edge -> 03.
// 4 out=01, start=1 mode=01 count=3 rotate=0 SIR=0 -> out 02,04,08 on successive edges; busy high 2 cycles; done pulses
//   once the cycle after out=08; mode=11 during busy has no effect.
// 5 start with count=0 -> out unchanged, busy=0, done pulse next cycle; start with mode=11 -> load only, no done.
// 6 burst count=F from out=FF SIR=0, assert clear after 5 shifts -> out=00, busy=0, done never pulses.

Source files
------------

// File: rtl/shift_register_universal.sv
// ---------------------------------------------------------------------------
// shift_register_universal
//
// WIDTH-bit universal shift register. It can hold, shift right, shift left or
// parallel-load, with optional rotate. A burst controller runs a programmed
// number of shifts without further input.
//
// "Right" shift moves data toward the MSB: out[0] takes the serial bit and
// out[WIDTH-1] leaves on serialOutRight. "Left" shift does the reverse.
//
// Ports
//   clockpulse        in   1            rising-edge clock
//   clear             in   1            synchronous active-high reset
//   mode              in   2            00 hold, 01 right, 10 left, 11 load
//   rotate            in   1            recirculate the shifted-out bit
//   serialInputRight  in   1            bit entering out[0] on right shift
//   serialInputLeft   in   1            bit entering out[WIDTH-1] on left shift
//   preset            in   WIDTH        parallel-load data
//   start             in   1            burst request (sampled while idle)
//   count             in   COUNT_WIDTH  burst length, sampled with start
//   out               out  WIDTH        register contents
//   notout            out  WIDTH        ~out
//   serialOutRight    out  1            out[WIDTH-1]
//   serialOutLeft     out  1            out[0]
//   busy              out  1            burst in progress
//   done              out  1            one-cycle pulse after the last burst shift
//   fsm_state         out  1            controller state (0 idle, 1 busy)
// ---------------------------------------------------------------------------
module shift_register_universal #(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clockpulse,
  input  logic                   clear,
  input  logic [1:0]             mode,
  input  logic                   rotate,
  input  logic                   serialInputRight,
  input  logic                   serialInputLeft,
  input  logic [WIDTH-1:0]       preset,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] count,
  output logic [WIDTH-1:0]       out,
  output logic [WIDTH-1:0]       notout,
  output logic                   serialOutRight,
  output logic                   serialOutLeft,
  output logic                   busy,
  output logic                   done,
  output logic                   fsm_state
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  state_t                 state, state_n;
  logic [COUNT_WIDTH-1:0] remaining, remaining_n;  // shifts still to do after this edge
  logic                   dir_left, dir_left_n;    // latched burst direction
  logic                   done_n;
  logic [WIDTH-1:0]       reg_q, reg_n;
  logic [WIDTH-1:0]       shift_r, shift_l;

  // Both shift results are always available; rotate and serial inputs stay
  // live during a burst.
  always_comb begin
    shift_r = {reg_q[WIDTH-2:0], (rotate ? reg_q[WIDTH-1] : serialInputRight)};
    shift_l = {(rotate ? reg_q[0] : serialInputLeft), reg_q[WIDTH-1:1]};
  end

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    dir_left_n  = dir_left;
    done_n      = 1'b0;
    reg_n       = reg_q;
    case (state)
      IDLE: begin
        if (start && (mode == MODE_RIGHT || mode == MODE_LEFT)) begin
          dir_left_n = (mode == MODE_LEFT);
          if (count == '0) begin
            // Empty burst: no shift, just report completion.
            done_n = 1'b1;
          end else begin
            // The accept edge performs the first shift.
            reg_n       = (mode == MODE_LEFT) ? shift_l : shift_r;
            remaining_n = count - COUNT_WIDTH'(1);
            if (count == COUNT_WIDTH'(1)) done_n = 1'b1;
            else                          state_n = BUSY;
          end
        end else begin
          case (mode)
            MODE_RIGHT: reg_n = shift_r;
            MODE_LEFT:  reg_n = shift_l;
            MODE_LOAD:  reg_n = preset;
            MODE_HOLD:  reg_n = reg_q;
            default:    reg_n = reg_q;
          endcase
        end
      end
      BUSY: begin
        reg_n       = dir_left ? shift_l : shift_r;
        remaining_n = remaining - COUNT_WIDTH'(1);
        if (remaining == COUNT_WIDTH'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clockpulse) begin
    if (clear) begin
      state     <= IDLE;
      remaining <= '0;
      dir_left  <= 1'b0;
      done      <= 1'b0;
      reg_q     <= '0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      dir_left  <= dir_left_n;
      done      <= done_n;
      reg_q     <= reg_n;
    end
  end

  assign out            = reg_q;
  assign notout         = ~reg_q;
  assign serialOutRight = reg_q[WIDTH-1];
  assign serialOutLeft  = reg_q[0];
  assign busy           = (state == BUSY);
  assign fsm_state      = state;

endmodule
